// File: rtl/player_motion.sv
// player_motion: two-player grid motion engine with IDLE/RUN/OVER game flow.
// Both heads step STEP_PX pixels every STEP_TICKS clocks along registered
// headings. A reversal request is ignored. Border and head-on collisions end
// the game and report a winner.
// Optional build macro MOTION_WRAP_EN: heads wrap around the screen edges
// instead of crashing, so only a head-on collision ends the game.

package game_pkg;
  typedef enum logic [2:0] {
    WAIT  = 3'd0,
    RIGHT = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    UP    = 3'd4
  } direction_t;
endpackage

module player_motion #(
  parameter int STEP_TICKS = 8_125_000,
  parameter int STEP_PX    = 4,
  parameter int X_MAX      = 1023,
  parameter int Y_MAX      = 767,
  parameter int X1_START   = 256,
  parameter int Y1_START   = 384,
  parameter int X2_START   = 767,
  parameter int Y2_START   = 384
) (
  input  logic                 clk,
  input  logic                 rst,
  input  game_pkg::direction_t direction_1,
  input  game_pkg::direction_t direction_2,
  input  logic                 restart,
  output logic [10:0]          x1,
  output logic [9:0]           y1,
  output logic [10:0]          x2,
  output logic [9:0]           y2,
  output logic                 step_strobe,
  output logic                 running,
  output logic                 game_over,
  output logic [1:0]           winner
);
  import game_pkg::*;

  localparam int TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(STEP_TICKS - 1);
  localparam logic [11:0] STEP_W = 12'(STEP_PX);
  localparam logic [11:0] X_LIM  = 12'(X_MAX);
  localparam logic [11:0] Y_LIM  = 12'(Y_MAX);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  // Result of one candidate step for a single player.
  typedef struct packed {
    direction_t  heading;
    logic [10:0] x;
    logic [9:0]  y;
    logic        crash;
  } move_t;

  // True when req points exactly against the current (moving) heading.
  function automatic logic is_reversal(direction_t req, direction_t cur);
    logic rev;
    rev = 1'b0;
    case (cur)
      RIGHT:   rev = (req == LEFT);
      LEFT:    rev = (req == RIGHT);
      DOWN:    rev = (req == UP);
      UP:      rev = (req == DOWN);
      default: rev = 1'b0;
    endcase
    return rev;
  endfunction

  // Computes the heading and position a player would take at the next update.
  // A crashing player keeps its position.
  function automatic move_t plan_move(direction_t req, direction_t cur,
                                      logic [10:0] x, logic [9:0] y);
    move_t       m;
    logic [11:0] xw;
    logic [11:0] yw;
    xw = {1'b0, x};
    yw = {2'b00, y};
    m.heading = is_reversal(req, cur) ? cur : req;
    m.x       = x;
    m.y       = y;
    m.crash   = 1'b0;
    case (m.heading)
      RIGHT: begin
        if (xw + STEP_W > X_LIM) begin
`ifdef MOTION_WRAP_EN
          m.x = 11'(xw + STEP_W - (X_LIM + 12'd1));
`else
          m.crash = 1'b1;
`endif
        end else begin
          m.x = 11'(xw + STEP_W);
        end
      end
      LEFT: begin
        if (xw < STEP_W) begin
`ifdef MOTION_WRAP_EN
          m.x = 11'(xw + X_LIM + 12'd1 - STEP_W);
`else
          m.crash = 1'b1;
`endif
        end else begin
          m.x = 11'(xw - STEP_W);
        end
      end
      DOWN: begin
        if (yw + STEP_W > Y_LIM) begin
`ifdef MOTION_WRAP_EN
          m.y = 10'(yw + STEP_W - (Y_LIM + 12'd1));
`else
          m.crash = 1'b1;
`endif
        end else begin
          m.y = 10'(yw + STEP_W);
        end
      end
      UP: begin
        if (yw < STEP_W) begin
`ifdef MOTION_WRAP_EN
          m.y = 10'(yw + Y_LIM + 12'd1 - STEP_W);
`else
          m.crash = 1'b1;
`endif
        end else begin
          m.y = 10'(yw - STEP_W);
        end
      end
      default: ;
    endcase
    return m;
  endfunction

  state_t        state_reg, state_next;
  logic [TW-1:0] tick_reg, tick_next;
  direction_t    heading_reg [2];
  direction_t    heading_next [2];
  logic [10:0]   x_reg [2];
  logic [10:0]   x_next [2];
  logic [9:0]    y_reg [2];
  logic [9:0]    y_next [2];
  logic          strobe_reg, strobe_next;
  logic [1:0]    winner_reg, winner_next;

  direction_t    req [2];
  logic [10:0]   x_start [2];
  logic [9:0]    y_start [2];
  move_t         move [2];
  logic          both_wait, head_on, crash_1, crash_2;

  assign req[0]     = direction_1;
  assign req[1]     = direction_2;
  assign x_start[0] = 11'(X1_START);
  assign x_start[1] = 11'(X2_START);
  assign y_start[0] = 10'(Y1_START);
  assign y_start[1] = 10'(Y2_START);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_player
      assign move[gi] = plan_move(req[gi], heading_reg[gi], x_reg[gi], y_reg[gi]);
    end
  endgenerate

  assign both_wait = (direction_1 == WAIT) && (direction_2 == WAIT);
  assign head_on   = (move[0].x == move[1].x) && (move[0].y == move[1].y);
  assign crash_1   = move[0].crash | head_on;
  assign crash_2   = move[1].crash | head_on;

  // Next-state logic: game flow, tick counting and position updates.
  always_comb begin
    state_next   = state_reg;
    tick_next    = tick_reg;
    heading_next = heading_reg;
    x_next       = x_reg;
    y_next       = y_reg;
    strobe_next  = 1'b0;
    winner_next  = winner_reg;
    case (state_reg)
      IDLE: begin
        tick_next       = '0;
        heading_next[0] = WAIT;
        heading_next[1] = WAIT;
        x_next          = x_start;
        y_next          = y_start;
        winner_next     = 2'b00;
        if (!both_wait) state_next = RUN;
      end
      RUN: begin
        if (tick_reg == TICK_LAST) begin
          tick_next = '0;
          if (crash_1 || crash_2) begin
            // A crash outranks a simultaneous both-WAIT request.
            state_next  = OVER;
            strobe_next = 1'b1;
            for (int p = 0; p < 2; p++) begin
              heading_next[p] = move[p].heading;
              x_next[p]       = move[p].x;
              y_next[p]       = move[p].y;
            end
            winner_next = (crash_1 && crash_2) ? 2'b10 :
                          crash_1              ? 2'b11 : 2'b01;
          end else if (both_wait) begin
            state_next      = IDLE;
            heading_next[0] = WAIT;
            heading_next[1] = WAIT;
            x_next          = x_start;
            y_next          = y_start;
          end else begin
            strobe_next = 1'b1;
            for (int p = 0; p < 2; p++) begin
              heading_next[p] = move[p].heading;
              x_next[p]       = move[p].x;
              y_next[p]       = move[p].y;
            end
          end
        end else begin
          tick_next = tick_reg + TW'(1);
          if (both_wait) begin
            state_next      = IDLE;
            tick_next       = '0;
            heading_next[0] = WAIT;
            heading_next[1] = WAIT;
            x_next          = x_start;
            y_next          = y_start;
          end
        end
      end
      OVER: begin
        if (restart) begin
          state_next      = IDLE;
          winner_next     = 2'b00;
          tick_next       = '0;
          heading_next[0] = WAIT;
          heading_next[1] = WAIT;
          x_next          = x_start;
          y_next          = y_start;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register with synchronous reset to the idle start condition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      tick_reg       <= '0;
      heading_reg[0] <= WAIT;
      heading_reg[1] <= WAIT;
      x_reg          <= x_start;
      y_reg          <= y_start;
      strobe_reg     <= 1'b0;
      winner_reg     <= 2'b00;
    end else begin
      state_reg   <= state_next;
      tick_reg    <= tick_next;
      heading_reg <= heading_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
      strobe_reg  <= strobe_next;
      winner_reg  <= winner_next;
    end
  end

  assign x1          = x_reg[0];
  assign y1          = y_reg[0];
  assign x2          = x_reg[1];
  assign y2          = y_reg[1];
  assign step_strobe = strobe_reg;
  assign running     = (state_reg == RUN);
  assign game_over   = (state_reg == OVER);
  assign winner      = winner_reg;

endmodule

// File: tb/tb_player_motion.sv
// tb_player_motion: drives two player_motion instances (default starts, and
// starts 8 px apart) with directed and random stimulus, comparing every
// output after every edge against a coordinate-level game model.
module tb_player_motion;
  import game_pkg::*;

  localparam int ST = 4;
  localparam int SP = 4;
  localparam int XM = 1023;
  localparam int YM = 767;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_OVER = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       restart = 1'b0;
  direction_t direction_1 = WAIT;
  direction_t direction_2 = WAIT;

  logic [10:0] x1_a, x2_a, x1_b, x2_b;
  logic [9:0]  y1_a, y2_a, y1_b, y2_b;
  logic        strobe_a, running_a, over_a, strobe_b, running_b, over_b;
  logic [1:0]  winner_a, winner_b;

  player_motion #(.STEP_TICKS(ST), .STEP_PX(SP)) dut_a (
    .clk(clk), .rst(rst), .direction_1(direction_1), .direction_2(direction_2),
    .restart(restart), .x1(x1_a), .y1(y1_a), .x2(x2_a), .y2(y2_a),
    .step_strobe(strobe_a), .running(running_a), .game_over(over_a), .winner(winner_a)
  );

  player_motion #(.STEP_TICKS(ST), .STEP_PX(SP), .X1_START(508), .X2_START(516)) dut_b (
    .clk(clk), .rst(rst), .direction_1(direction_1), .direction_2(direction_2),
    .restart(restart), .x1(x1_b), .y1(y1_b), .x2(x2_b), .y2(y2_b),
    .step_strobe(strobe_b), .running(running_b), .game_over(over_b), .winner(winner_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Pixel displacement per heading index WAIT, RIGHT, DOWN, LEFT, UP.
  int dxv [5] = '{0, SP, 0, -SP, 0};
  int dyv [5] = '{0, 0, SP, 0, -SP};
  int sx [2][2] = '{'{256, 767}, '{508, 516}};
  int sy [2][2] = '{'{384, 384}, '{384, 384}};

  int m_mode [2];
  int m_tick [2];
  int m_win [2];
  int m_strobe [2];
  int mx [2][2];
  int my [2][2];
  int mh [2][2];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_home(input int k);
    for (int p = 0; p < 2; p++) begin
      mx[k][p] = sx[k][p];
      my[k][p] = sy[k][p];
      mh[k][p] = 0;
    end
    m_tick[k] = 0;
  endtask

  task automatic model_edge(input int k, input int d1, input int d2, input bit rs, input bit rr);
    int req [2];
    int nh [2];
    int nx [2];
    int ny [2];
    bit cr [2];
    bit both;
    req[0] = d1;
    req[1] = d2;
    both = (d1 == 0) && (d2 == 0);
    m_strobe[k] = 0;
    if (rr) begin
      model_home(k);
      m_mode[k] = M_IDLE;
      m_win[k]  = 0;
    end else if (m_mode[k] == M_IDLE) begin
      if (!both) m_mode[k] = M_RUN;
    end else if (m_mode[k] == M_OVER) begin
      if (rs) begin
        m_mode[k] = M_IDLE;
        m_win[k]  = 0;
        model_home(k);
      end
    end else if (m_tick[k] != ST - 1) begin
      m_tick[k]++;
      if (both) begin
        m_mode[k] = M_IDLE;
        model_home(k);
      end
    end else begin
      m_tick[k] = 0;
      for (int p = 0; p < 2; p++) begin
        nh[p] = req[p];
        if (mh[k][p] != 0 && req[p] != 0 &&
            dxv[req[p]] == -dxv[mh[k][p]] && dyv[req[p]] == -dyv[mh[k][p]])
          nh[p] = mh[k][p];
        nx[p] = mx[k][p] + dxv[nh[p]];
        ny[p] = my[k][p] + dyv[nh[p]];
        cr[p] = 1'b0;
`ifdef MOTION_WRAP_EN
        nx[p] = (nx[p] + XM + 1) % (XM + 1);
        ny[p] = (ny[p] + YM + 1) % (YM + 1);
`else
        if (nx[p] < 0 || nx[p] > XM || ny[p] < 0 || ny[p] > YM) begin
          cr[p] = 1'b1;
          nx[p] = mx[k][p];
          ny[p] = my[k][p];
        end
`endif
      end
      if (nx[0] == nx[1] && ny[0] == ny[1]) begin
        cr[0] = 1'b1;
        cr[1] = 1'b1;
      end
      if (cr[0] || cr[1] || !both) begin
        for (int p = 0; p < 2; p++) begin
          mx[k][p] = nx[p];
          my[k][p] = ny[p];
          mh[k][p] = nh[p];
        end
        m_strobe[k] = 1;
        if (cr[0] || cr[1]) begin
          m_mode[k] = M_OVER;
          m_win[k]  = (cr[0] && cr[1]) ? 2 : (cr[0] ? 3 : 1);
        end
      end else begin
        m_mode[k] = M_IDLE;
        model_home(k);
      end
    end
  endtask

  task automatic compare_inst(input string tag, input int k, input int x1, input int y1,
                              input int x2, input int y2, input int stb, input int run,
                              input int ovr, input int win);
    check($sformatf("%s.x1", tag), x1, mx[k][0]);
    check($sformatf("%s.y1", tag), y1, my[k][0]);
    check($sformatf("%s.x2", tag), x2, mx[k][1]);
    check($sformatf("%s.y2", tag), y2, my[k][1]);
    check($sformatf("%s.step_strobe", tag), stb, m_strobe[k]);
    check($sformatf("%s.running", tag), run, (m_mode[k] == M_RUN) ? 1 : 0);
    check($sformatf("%s.game_over", tag), ovr, (m_mode[k] == M_OVER) ? 1 : 0);
    check($sformatf("%s.winner", tag), win, m_win[k]);
  endtask

  // One clock: apply inputs, advance both models on the edge, compare after it.
  task automatic cycle(input int d1, input int d2, input bit rs, input bit rr);
    direction_1 = direction_t'(d1);
    direction_2 = direction_t'(d2);
    restart     = rs;
    rst         = rr;
    @(posedge clk);
    model_edge(0, d1, d2, rs, rr);
    model_edge(1, d1, d2, rs, rr);
    #1;
    compare_inst("A", 0, int'(x1_a), int'(y1_a), int'(x2_a), int'(y2_a),
                 int'(strobe_a), int'(running_a), int'(over_a), int'(winner_a));
    compare_inst("B", 1, int'(x1_b), int'(y1_b), int'(x2_b), int'(y2_b),
                 int'(strobe_b), int'(running_b), int'(over_b), int'(winner_b));
  endtask

  function automatic int pick_dir();
    if ($urandom_range(0, 99) < 15) return 0;
    return int'($urandom_range(1, 4));
  endfunction

  initial begin
    int strobes;
    int budget;
    int d1;
    int d2;

    // Reset state.
    cycle(0, 0, 0, 1);
    check("reset.x1", int'(x1_a), 256);
    check("reset.x2", int'(x2_a), 767);
    check("reset.winner", int'(winner_a), 0);

    // Player 1 heading right; player 2 waits.
    cycle(1, 0, 0, 0);
    check("run_entry.running", int'(running_a), 1);
    repeat (8) cycle(1, 0, 0, 0);
    check("right.x1", int'(x1_a), 264);
    check("right.y1", int'(y1_a), 384);
    check("right.x2_still", int'(x2_a), 767);

    // Reversal request is ignored.
    repeat (8) cycle(3, 0, 0, 0);
    check("reverse_ignored.x1", int'(x1_a), 272);

    // Both WAIT mid-run returns to idle at the start positions.
    cycle(0, 0, 0, 0);
    check("both_wait.running", int'(running_a), 0);
    check("both_wait.x1", int'(x1_a), 256);

    // Reset between strobes mid-run.
    repeat (3) cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 1);
    check("rst_mid.step_strobe", int'(strobe_a), 0);
    check("rst_mid.running", int'(running_a), 0);
    check("rst_mid.x1", int'(x1_a), 256);

    // Player 1 runs left into the border.
    strobes = 0;
    budget  = 0;
    while (strobes < 65 && budget < 400) begin
      cycle(3, 0, 0, 0);
      budget++;
      if (strobe_a) strobes++;
    end
    check("left_wall.strobes", strobes, 65);
`ifdef MOTION_WRAP_EN
    check("left_wrap.x1", int'(x1_a), 1020);
    check("left_wrap.running", int'(running_a), 1);
`else
    check("left_wall.x1", int'(x1_a), 0);
    check("left_wall.game_over", int'(over_a), 1);
    check("left_wall.winner", int'(winner_a), 3);
    repeat (6) cycle(1, 4, 0, 0);
    check("over_frozen.x1", int'(x1_a), 0);
    check("over_frozen.winner", int'(winner_a), 3);
    cycle(1, 4, 1, 0);
    check("restart.x1", int'(x1_a), 256);
    check("restart.x2", int'(x2_a), 767);
    check("restart.winner", int'(winner_a), 0);
    check("restart.game_over", int'(over_a), 0);
`endif

    // Head-on collision on instance B (508 right meets 516 left).
    cycle(0, 0, 0, 1);
    repeat (5) cycle(1, 3, 0, 0);
    check("head_on.x1", int'(x1_b), 512);
    check("head_on.x2", int'(x2_b), 512);
    check("head_on.winner", int'(winner_b), 2);
    check("head_on.game_over", int'(over_b), 1);

    // Random play with occasional restart and reset.
    d1 = 0;
    d2 = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) d1 = pick_dir();
      if ($urandom_range(0, 5) == 0) d2 = pick_dir();
      cycle(d1, d2, $urandom_range(0, 19) == 0, $urandom_range(0, 499) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/player_motion.md
PLAYER_MOTION -- requirements
Module: player_motion

Interface
REQ-001 Parameter STEP_TICKS, default 8_125_000, SHALL be the number of clk cycles between position updates.
REQ-002 Parameter STEP_PX, default 4, SHALL be the pixels moved per update.
REQ-003 Parameters X_MAX, default 1023, and Y_MAX, default 767, SHALL be the last valid pixel coordinates.
REQ-004 Parameters X1_START/Y1_START, default 256/384, and X2_START/Y2_START, default 767/384, SHALL be the start positions.
REQ-005 clk  in  1  system clock; reset rst, synchronous, active-high; clock clk.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 direction_1, direction_2  in  directions (game_pkg)  requested heading per player, WAIT/RIGHT/DOWN/LEFT/UP.
REQ-008 restart  in  1  single-cycle pulse returning the block from OVER to IDLE.
REQ-009 x1, x2  out  11  player head x; y1, y2  out  10  player head y.
REQ-010 step_strobe  out  1  one-cycle pulse on the edge at which positions update.
REQ-011 running  out  1  high in RUN; game_over  out  1  high in OVER.
REQ-012 winner  out  2  01 player 1, 11 player 2, 10 draw, 00 none.

Function
REQ-013 FSM states SHALL be IDLE, RUN and OVER.
REQ-014 IDLE: positions held at start values, tick counter 0; transition to RUN on the first cycle either direction input is not WAIT.
REQ-015 RUN: tick counter SHALL count 0..STEP_TICKS-1; at count STEP_TICKS-1 it SHALL wrap to 0, and positions plus step_strobe SHALL update on that same edge.
REQ-016 Each player SHALL hold a registered motion heading sampled from its direction input at each update; WAIT SHALL leave that player stationary.
REQ-017 A requested heading exactly opposite the current non-WAIT motion heading SHALL be ignored, and the previous heading kept.
REQ-018 Arithmetic SHALL use 12-bit intermediates; RIGHT adds STEP_PX to x, LEFT subtracts, DOWN adds to y, UP subtracts.
REQ-019 Border crash: LEFT with x<STEP_PX, UP with y<STEP_PX, RIGHT with x+STEP_PX>X_MAX, or DOWN with y+STEP_PX>Y_MAX; the crashing player's position SHALL NOT change.
REQ-020 Head-on crash: updated positions equal SHALL count as a crash of both players.
REQ-021 Any crash SHALL move the FSM to OVER on the update edge. Winner SHALL be 01 if only player 2 crashed, 11 if only player 1 crashed, and 10 if both crashed.
REQ-022 OVER: positions, winner and game_over SHALL be frozen; direction inputs ignored; restart SHALL go to IDLE next edge and clear winner.
REQ-023 RUN with both direction inputs WAIT in the same cycle SHALL return to IDLE next edge, restoring start positions, with no winner.
REQ-024 restart outside OVER SHALL be ignored.
REQ-025 A crash and both-WAIT in the same update cycle: crash SHALL take priority.

Reset
REQ-026 rst SHALL force IDLE, tick counter 0, headings WAIT, positions to start values, step_strobe 0, running 0, game_over 0, winner 00.
REQ-027 rst mid-RUN or in OVER SHALL take effect on the next edge, overriding every other event.

Configuration
REQ-028 Macro MOTION_WRAP_EN defined: border crossing SHALL wrap modulo (X_MAX+1)/(Y_MAX+1) instead of crashing; only head-on crash ends the game.
REQ-029 Macro MOTION_WRAP_EN undefined: border behaviour per REQ-019.

Verification (STEP_TICKS=4, STEP_PX=4, defaults otherwise)
REQ-030 Reset, then direction_1=RIGHT held -> RUN next edge; step_strobe every 4 cycles; x1 256,260,264; y1 stays 384; player 2 stays at 767/384.
REQ-031 Player 1 at x1=0 heading LEFT -> next update x1 stays 0, game_over=1, winner=11; with MOTION_WRAP_EN, x1=1020 and running stays 1.
REQ-032 Player 1 heading RIGHT, direction_1=LEFT requested -> x1 keeps increasing by 4 per update.
REQ-033 Players converging on same cell, such as x1=508 RIGHT and x2=516 LEFT, y equal -> both 512, game_over=1, winner=10.
REQ-034 In OVER, restart pulse -> IDLE, positions 256/384 and 767/384, winner=00; both directions WAIT mid-RUN -> IDLE with start positions.
REQ-035 rst asserted between strobes mid-RUN -> all outputs at reset values next edge; no step_strobe is emitted.
